// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Operands are reduced to magnitudes on accept, divided unsigned, and the
// signs are restored in a single fix-up cycle that also registers the
// outputs. A zero divisor skips the iteration entirely.
module seq_divider #(
    parameter int WIDTH_N = 8,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_zero,
    output logic               overflow
);

    localparam int CNT_W = $clog2(WIDTH_N + 1);
    localparam logic [WIDTH_N-1:0] MIN_N = {1'b1, {(WIDTH_N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Iteration state: dvd shifts out dividend bits on the left and collects
    // quotient bits on the right, so it ends the run holding |quotient|.
    logic [WIDTH_N-1:0] dvd;
    logic [WIDTH_D-1:0] dsr;
    logic [WIDTH_D-1:0] rem;
    logic [CNT_W-1:0]   cnt;
    logic               sgn_mode;
    logic               sgn_n;
    logic               sgn_d;
    logic               dz;
    logic               ovf;

    // Accept-time decode
    logic               dz_in;
    logic               ovf_in;

    // One restoring step
    logic [WIDTH_D:0]   rem_sh;
    logic               ge;
    logic [WIDTH_D-1:0] diff;
    logic [WIDTH_D-1:0] rem_nxt;

    // Fix-up results
    logic [WIDTH_N-1:0] q_fix;
    logic [WIDTH_D-1:0] r_fix;

    function automatic logic [WIDTH_N-1:0] neg_n(input logic [WIDTH_N-1:0] v);
        return ~v + WIDTH_N'(1);
    endfunction

    function automatic logic [WIDTH_D-1:0] neg_d(input logic [WIDTH_D-1:0] v);
        return ~v + WIDTH_D'(1);
    endfunction

    // Absolute value in signed mode; the most negative value maps onto its
    // own bit pattern, which is the correct unsigned magnitude.
    function automatic logic [WIDTH_N-1:0] mag_n(input logic [WIDTH_N-1:0] v,
                                                 input logic sgn);
        return (sgn && v[WIDTH_N-1]) ? neg_n(v) : v;
    endfunction

    function automatic logic [WIDTH_D-1:0] mag_d(input logic [WIDTH_D-1:0] v,
                                                 input logic sgn);
        return (sgn && v[WIDTH_D-1]) ? neg_d(v) : v;
    endfunction

    // Dividend resized into the remainder field: truncate or zero-extend.
    function automatic logic [WIDTH_D-1:0] fit_d(input logic [WIDTH_N-1:0] v);
        return WIDTH_D'(v);
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign dz_in  = (divisor == '0);
    assign ovf_in = is_signed && (dividend == MIN_N) && (divisor == '1);

    // Shifted remainder is one bit wider than the divisor so the compare is
    // exact; the difference is always below |divisor| and fits WIDTH_D bits.
    always_comb begin
        rem_sh  = {rem, dvd[WIDTH_N-1]};
        ge      = (rem_sh >= {1'b0, dsr});
        diff    = rem_sh[WIDTH_D-1:0] - dsr;
        rem_nxt = ge ? diff : rem_sh[WIDTH_D-1:0];
    end

    // Sign restoration, plus the fixed zero-divisor result pattern.
    always_comb begin
        q_fix = dvd;
        r_fix = rem;
        if (dz) begin
            q_fix = '1;
            r_fix = fit_d(dvd);
        end else begin
            if (sgn_mode && (sgn_n ^ sgn_d)) q_fix = neg_n(dvd);
            if (sgn_mode && sgn_n)           r_fix = neg_d(rem);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = dz_in ? FIX : RUN;
            RUN:  if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one restoring step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sgn_mode <= 1'b0;
            sgn_n    <= 1'b0;
            sgn_d    <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // A zero divisor keeps the raw dividend for the
                        // remainder field instead of its magnitude.
                        dvd      <= dz_in ? dividend : mag_n(dividend, is_signed);
                        dsr      <= mag_d(divisor, is_signed);
                        rem      <= '0;
                        cnt      <= CNT_W'(WIDTH_N);
                        sgn_mode <= is_signed;
                        sgn_n    <= dividend[WIDTH_N-1];
                        sgn_d    <= divisor[WIDTH_D-1];
                        dz       <= dz_in;
                        ovf      <= ovf_in;
                    end
                end
                RUN: begin
                    dvd <= {dvd[WIDTH_N-2:0], ge};
                    rem <= rem_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers load only in FIX and otherwise hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == FIX) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            div_zero  <= dz;
            overflow  <= ovf;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for an 8/8 and a 16/5 seq_divider.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv8, ir8, s8, ovld8, ordy8, dz8, of8;
    logic [7:0]  a8, b8, q8, r8;

    logic        iv16, ir16, s16, ovld16, ordy16, dz16, of16;
    logic [15:0] a16, q16;
    logic [4:0]  b16, r16;

    seq_divider #(.WIDTH_N(8), .WIDTH_D(8)) u_div8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .dividend(a8), .divisor(b8), .is_signed(s8),
        .out_valid(ovld8), .out_ready(ordy8), .quotient(q8), .remainder(r8),
        .div_zero(dz8), .overflow(of8)
    );

    seq_divider #(.WIDTH_N(16), .WIDTH_D(5)) u_div16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .dividend(a16), .divisor(b16), .is_signed(s16),
        .out_valid(ovld16), .out_ready(ordy16), .quotient(q16), .remainder(r16),
        .div_zero(dz16), .overflow(of16)
    );

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   cyc = 0;
    int   c0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: native integer division truncates toward zero.
    function automatic exp_t model(input int nw, input int dw, input logic [15:0] a,
                                   input logic [7:0] b, input logic sgn);
        exp_t   e;
        longint mn, md, sa, sd, qq, rr;
        mn = (longint'(1) << nw) - 1;
        md = (longint'(1) << dw) - 1;
        sa = longint'(a) & mn;
        sd = longint'(b) & md;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = nw + 1;
        if (sd == 0) begin
            e.q   = 16'(mn);
            e.r   = 8'(sa & md);
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            if (sgn && sa[nw-1]) sa = sa - (longint'(1) << nw);
            if (sgn && sd[dw-1]) sd = sd - (longint'(1) << dw);
            if (sgn && sa == -(longint'(1) << (nw - 1)) && sd == -1) begin
                qq   = longint'(1) << (nw - 1);
                rr   = 0;
                e.ov = 1'b1;
            end else begin
                qq = sa / sd;
                rr = sa % sd;
            end
            e.q = 16'(qq & mn);
            e.r = 8'(rr & md);
        end
        return e;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? ir16 : ir8;
    endfunction
    function automatic logic ovld(input int sel);
        return (sel != 0) ? ovld16 : ovld8;
    endfunction
    function automatic logic [15:0] qv(input int sel);
        return (sel != 0) ? q16 : {8'h00, q8};
    endfunction
    function automatic logic [7:0] rv(input int sel);
        return (sel != 0) ? {3'b000, r16} : r8;
    endfunction
    function automatic logic dzv(input int sel);
        return (sel != 0) ? dz16 : dz8;
    endfunction
    function automatic logic ofv(input int sel);
        return (sel != 0) ? of16 : of8;
    endfunction

    task automatic set_ordy(input int sel, input logic v);
        if (sel != 0) ordy16 = v;
        else          ordy8  = v;
    endtask

    // Present operands, push the expected result, hold until accepted.
    task automatic issue(input int sel, input logic [15:0] a, input logic [7:0] b,
                         input logic sgn, input logic push);
        @(negedge clk);
        if (sel != 0) begin a16 = a; b16 = b[4:0]; s16 = sgn; iv16 = 1'b1; end
        else          begin a8 = a[7:0]; b8 = b;  s8 = sgn;  iv8 = 1'b1;  end
        if (push) sb.push_back(model((sel != 0) ? 16 : 8, (sel != 0) ? 5 : 8, a, b, sgn));
        for (int i = 0; i < 50 && !rdy(sel); i++) @(negedge clk);
        check("in_ready_before_accept", rdy(sel), 1);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        iv8  = 1'b0;
        iv16 = 1'b0;
    endtask

    // Wait for a result and compare it against the scoreboard head.
    task automatic wait_result(input int sel);
        int lat;
        for (int i = 0; i < 40 && !ovld(sel); i++) @(negedge clk);
        lat = cyc - c0;
        check("out_valid_rise", ovld(sel), 1);
        if (sb.size() == 0) begin
            $display("FAIL sb_underflow: no expected result queued");
            $fatal(1);
        end
        last = sb.pop_front();
        check("quotient", qv(sel), last.q);
        check("remainder", rv(sel), last.r);
        check("div_zero", dzv(sel), last.dz);
        check("overflow", ofv(sel), last.ov);
        check("latency", lat, last.lat);
    endtask

    task automatic consume(input int sel);
        set_ordy(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ordy(sel, 1'b0);
        check("out_valid_fall", ovld(sel), 0);
        check("in_ready_rise", rdy(sel), 1);
        check("quotient_kept", qv(sel), last.q);
    endtask

    task automatic run_div(input int sel, input logic [15:0] a, input logic [7:0] b,
                           input logic sgn);
        issue(sel, a, b, sgn, 1'b1);
        wait_result(sel);
        consume(sel);
    endtask

    task automatic check_reset_state(input int sel);
        check("rst_in_ready", rdy(sel), 1);
        check("rst_out_valid", ovld(sel), 0);
        check("rst_quotient", qv(sel), 0);
        check("rst_remainder", rv(sel), 0);
        check("rst_div_zero", dzv(sel), 0);
        check("rst_overflow", ofv(sel), 0);
    endtask

    // Abort a run with a reset pulse around E4, then run a fresh division.
    task automatic abort_then(input int sel, input logic [15:0] a, input logic [7:0] b);
        logic seen;
        issue(sel, a, b, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen = seen | ovld(sel);
        end
        check("abort_no_out_valid", seen, 0);
        check("abort_in_ready", rdy(sel), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; ordy8 = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; ordy16 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst_n = 1'b1;

        // Unsigned 8/8
        run_div(0, 16'd200, 8'd7, 1'b0);
        run_div(0, 16'd255, 8'd1, 1'b0);
        run_div(0, 16'd5, 8'd9, 1'b0);
        // Signed 8/8
        run_div(0, 16'h00F9, 8'h02, 1'b1);
        run_div(0, 16'h0007, 8'hFE, 1'b1);
        run_div(0, 16'h0080, 8'hFF, 1'b1);
        // Divide by zero, both modes
        run_div(0, 16'h005A, 8'h00, 1'b0);
        run_div(0, 16'h005A, 8'h00, 1'b1);
        // 16/5 corners
        run_div(1, 16'd40000, 8'd17, 1'b0);
        run_div(1, 16'h8000, 8'h1F, 1'b1);
        run_div(1, 16'hA5C3, 8'h00, 1'b1);
        run_div(1, 16'hFFFF, 8'h10, 1'b1);

        // Back-pressure: new operands wait while the result is held
        issue(0, 16'd100, 8'd7, 1'b0, 1'b1);
        wait_result(0);
        a8 = 8'd50; b8 = 8'd6; s8 = 1'b0; iv8 = 1'b1;
        sb.push_back(model(8, 8, 16'd50, 8'd6, 1'b0));
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", ovld8, 1);
            check("bp_in_ready", ir8, 0);
            check("bp_quotient", {8'h00, q8}, last.q);
            check("bp_remainder", r8, last.r);
        end
        ordy8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy8 = 1'b0;
        check("bp_consume_out_valid", ovld8, 0);
        check("bp_consume_in_ready", ir8, 1);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        iv8 = 1'b0;
        check("bp_accepted", ir8, 0);
        wait_result(0);
        consume(0);

        // Asynchronous reset mid-cycle while a result is held
        issue(0, 16'h005A, 8'h00, 1'b0, 1'b1);
        wait_result(0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort and recovery, both widths
        abort_then(0, 16'd200, 8'd7);
        run_div(0, 16'd100, 8'd3, 1'b0);
        abort_then(1, 16'd40000, 8'd17);
        run_div(1, 16'd40000, 8'd17, 1'b0);

        // Random mix across both instances
        repeat (40) begin
            int          sel;
            logic [15:0] a;
            logic [7:0]  b;
            logic        sgn;
            sel = int'($urandom_range(0, 1));
            a   = 16'($urandom);
            b   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if (sel != 0 && b[4:0] == 5'd0) b = 8'h00;
            sgn = 1'($urandom_range(0, 1));
            run_div(sel, a, b, sgn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle restoring divider with a valid/ready handshake, per-transaction signed/unsigned mode, and divide-by-zero and overflow flags. It computes one quotient bit per clock, so the cost is one subtract/compare datapath regardless of width. It is the general-purpose integer divider for the datapath: upstream logic issues operands, and downstream logic consumes the quotient and remainder under back-pressure.

## Interface
- WIDTH_N, 8: dividend and quotient width in bits; must be 2 or more.
- WIDTH_D, 8: divisor and remainder width in bits; must be 2 or more.
- clk  input  1  the only clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands present on dividend, divisor and is_signed.
- in_ready  output  1  high only in IDLE; a transfer occurs on an edge where in_valid && in_ready.
- dividend  input  WIDTH_N  numerator.
- divisor  input  WIDTH_D  denominator.
- is_signed  input  1  1 = two's-complement operands and results; 0 = unsigned.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result on an edge where out_valid && out_ready.
- quotient  output  WIDTH_N  registered quotient.
- remainder  output  WIDTH_D  registered remainder.
- div_zero  output  1  result came from a zero divisor.
- overflow  output  1  signed quotient was not representable.

## Operation
- States: IDLE, RUN, FIX, DONE. Reset state is IDLE.
- IDLE -> RUN on accept, when the divisor is non-zero.
  - Latch the magnitude of the dividend and the magnitude of the divisor. Magnitude is the absolute value when is_signed=1, else the raw value.
  - Latch the signs and is_signed.
  - Clear the partial remainder.
  - Load the bit counter with WIDTH_N.
- IDLE -> FIX on accept with divisor == 0.
- RUN: each cycle, shift the partial remainder left and bring in the next dividend MSB.
  - If the shifted remainder is >= |divisor|, subtract |divisor| and shift in quotient bit 1; otherwise shift in 0.
  - The partial remainder is WIDTH_D+1 bits wide so the compare cannot overflow.
  - Decrement the counter; when it reaches 0, go to FIX.
- FIX: correct signs and register the outputs, then go to DONE.
  - Signed: negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative. Division truncates toward zero and the remainder takes the dividend's sign.
  - Zero divisor: quotient = all ones, remainder = dividend[WIDTH_D-1:0] (zero-extended if WIDTH_D > WIDTH_N), div_zero=1. Same in both modes.
  - Signed, dividend = -2^(WIDTH_N-1), divisor = -1: quotient = 2^(WIDTH_N-1) bit pattern (the most negative value), remainder 0, overflow=1.
  - Otherwise div_zero=0 and overflow=0.
- DONE: out_valid=1. Outputs and flags are held stable while out_ready=0. On an edge with out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. A new accept cannot occur on the same edge as result consumption.
- Reset at any time, including mid-RUN:
  - Immediately go to IDLE.
  - out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0, internal counter and remainder cleared.
  - in_ready=1 once reset is released.

## Timing
- in_ready and out_valid are decoded directly from the state register, with no combinational path from inputs.
- Accept occurs on edge E0.
  - Normal division: RUN on edges E1..E_WIDTH_N, FIX on edge E_WIDTH_N+1. out_valid is high from after edge E_WIDTH_N+1, giving a latency of WIDTH_N+1 cycles.
  - Divide-by-zero: FIX on edge E1, out_valid high after E1, giving a latency of 1 cycle.
- Consume edge Ec: out_valid falls and in_ready rises after Ec. The earliest next accept is edge Ec+1.
- Throughput without back-pressure: one division per WIDTH_N+3 cycles.
- Outputs keep their last values after consumption, until the next FIX or reset.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> immediately in_ready=1, out_valid=0, quotient=0, remainder=0, both flags 0.
- Unsigned, 8/8: accept 200/7 at E0 -> out_valid after E9, quotient=28, remainder=4, flags 0. Also 255/1 -> 255 r 0. Also 5/9 -> 0 r 5.
- Signed, 8/8:
  - -7/2 -> quotient 0xFD (-3), remainder 0xFF (-1).
  - 7/-2 -> 0xFD r 0x01.
  - -128/-1 -> quotient 0x80, remainder 0, overflow=1, out_valid after E9.
- Divide-by-zero: 0x5A/0, either mode -> out_valid after E1, quotient=0xFF, remainder=0x5A, div_zero=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and new operands presented -> outputs stable, in_ready=0, new operands not accepted. Then raise out_ready -> in_ready rises the next cycle and the held operands are accepted on the following edge.
- Abort and parameter sweep:
  - Pulse rst_n low at E4 of a 200/7 run -> no out_valid; a fresh 100/3 afterwards returns 33 r 1.
  - Repeat with WIDTH_N=16, WIDTH_D=5: 40000/17 -> 2352 r 16, latency 17 cycles.
